lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller between the MEM stage and a
// word-wide, little-endian data memory with a req/gnt + rvalid handshake.
// Handles byte/half/word accesses, including misaligned accesses that
// straddle a word boundary (split into two beats), and flags illegal func3.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   lsu_valid           request from MEM stage (held with fields until done)
//   lsu_we              1 = store, 0 = load
//   lsu_func3[2:0]      000 b, 001 h, 010 w, 100 bu, 101 hu (others illegal)
//   lsu_addr[31:0]      byte address
//   lsu_wdata[31:0]     right-justified store data
//   lsu_stall           pipeline hold (lsu_valid & ~lsu_done)
//   lsu_done            one-cycle completion pulse
//   lsu_err             one-cycle pulse with lsu_done for illegal func3
//   lsu_rdata[31:0]     aligned, extended load result (held until next load)
//   dm_req / dm_gnt     memory request / accept
//   dm_we               write beat
//   dm_addr[31:0]       word address (bits [1:0] always 0)
//   dm_wstrb[3:0]       byte-lane write enables
//   dm_wdata[31:0]      lane-positioned write data
//   dm_rvalid, dm_rdata read response
// ---------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_func3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        dm_req,
  input  logic        dm_gnt,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state, state_next;
  logic        beat, beat_next;
  logic        split_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf0, buf1;

  logic        take;
  logic        cap;
  logic        rdata_load;
  logic        sel_we;
  logic [2:0]  sel_func3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [7:0]  sel_mask;
  logic [63:0] sel_data;
  logic        dm_req_next;
  logic        dm_we_next;
  logic [31:0] dm_addr_next;
  logic [3:0]  dm_wstrb_next;
  logic [31:0] dm_wdata_next;
  logic        done_next;
  logic        err_next;
  logic [63:0] rsp_cat;
  logic [31:0] rdata_next;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Byte-enable pattern across two adjacent words: low nibble is beat0,
  // high nibble is beat1.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Store data truncated to the access size and moved to its byte lanes
  // across two adjacent words.
  function automatic logic [63:0] lane_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] wd);
    logic [63:0] d;
    case (f3[1:0])
      2'b00:   d = {56'd0, wd[7:0]};
      2'b01:   d = {48'd0, wd[15:0]};
      default: d = {32'd0, wd};
    endcase
    return d << {off, 3'b000};
  endfunction

  // Extract the addressed bytes from the two-word buffer and extend.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [63:0] cat);
    logic [31:0] sh;
    sh = 32'(cat >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign lsu_stall = lsu_valid & ~lsu_done;

  // State register plus all registered outputs; every dm_* output is a flop
  // so nothing from the lsu_* side reaches memory combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= 1'b0;
      split_q   <= 1'b0;
      we_q      <= 1'b0;
      func3_q   <= 3'b000;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      buf0      <= 32'd0;
      buf1      <= 32'd0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= 32'd0;
      dm_wstrb  <= 4'd0;
      dm_wdata  <= 32'd0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'd0;
    end else begin
      state    <= state_next;
      beat     <= beat_next;
      dm_req   <= dm_req_next;
      dm_we    <= dm_we_next;
      lsu_done <= done_next;
      lsu_err  <= err_next;
      if (dm_req_next) begin
        dm_addr  <= dm_addr_next;
        dm_wstrb <= dm_wstrb_next;
        dm_wdata <= dm_wdata_next;
      end
      if (take) begin
        we_q    <= lsu_we;
        func3_q <= lsu_func3;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        split_q <= |sel_mask[7:4];
      end
      if (cap) begin
        if (beat) buf1 <= dm_rdata;
        else      buf0 <= dm_rdata;
      end
      if (rdata_load) lsu_rdata <= rdata_next;
    end
  end

  // Next-state logic and the values the output flops load next cycle.
  // In IDLE the incoming request fields are used directly so the first
  // beat is presented in the cycle right after acceptance.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    take       = 1'b0;
    cap        = 1'b0;
    rdata_load = 1'b0;

    sel_we    = (state == IDLE) ? lsu_we    : we_q;
    sel_func3 = (state == IDLE) ? lsu_func3 : func3_q;
    sel_addr  = (state == IDLE) ? lsu_addr  : addr_q;
    sel_wdata = (state == IDLE) ? lsu_wdata : wdata_q;
    sel_mask  = lane_mask(sel_func3, sel_addr[1:0]);
    sel_data  = lane_data(sel_func3, sel_addr[1:0], sel_wdata);

    // The beat being answered is merged with the other buffer so the final
    // result is available in the same cycle the last response arrives.
    rsp_cat    = beat ? {dm_rdata, buf0} : {buf1, dm_rdata};
    rdata_next = load_extract(func3_q, addr_q[1:0], rsp_cat);

    case (state)
      IDLE: begin
        if (lsu_valid) begin
          take      = 1'b1;
          beat_next = 1'b0;
          state_next = is_illegal(lsu_func3) ? DONE : REQ;
        end
      end
      REQ: begin
        if (dm_gnt) begin
          if (!we_q) begin
            state_next = RSP;
          end else if (split_q && !beat) begin
            state_next = REQ;
            beat_next  = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      RSP: begin
        if (dm_rvalid) begin
          cap = 1'b1;
          if (split_q && !beat) begin
            state_next = REQ;
            beat_next  = 1'b1;
          end else begin
            state_next = DONE;
            rdata_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    dm_req_next   = (state_next == REQ);
    dm_we_next    = dm_req_next & sel_we;
    dm_addr_next  = {sel_addr[31:2], 2'b00} + {29'd0, beat_next, 2'b00};
    dm_wstrb_next = 4'd0;
    dm_wdata_next = 32'd0;
    if (sel_we) begin
      dm_wstrb_next = beat_next ? sel_mask[7:4]   : sel_mask[3:0];
      dm_wdata_next = beat_next ? sel_data[63:32] : sel_data[31:0];
    end

    // DONE is reached straight from IDLE only for an illegal func3.
    done_next = (state_next == DONE);
    err_next  = done_next && (state == IDLE);
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl. A byte-level reference
// model derives the expected memory beats, load result and latency of each
// request; a per-cycle compare process checks the DUT against it, and a few
// literal expectations pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_func3 = 3'b000;
  logic [31:0] lsu_addr = 32'd0;
  logic [31:0] lsu_wdata = 32'd0;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        dm_req;
  logic        dm_gnt = 1'b0;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = 32'd0;

  lsu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu_valid (lsu_valid),
    .lsu_we    (lsu_we),
    .lsu_func3 (lsu_func3),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_stall (lsu_stall),
    .lsu_done  (lsu_done),
    .lsu_err   (lsu_err),
    .lsu_rdata (lsu_rdata),
    .dm_req    (dm_req),
    .dm_gnt    (dm_gnt),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wstrb  (dm_wstrb),
    .dm_wdata  (dm_wdata),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state for the request in flight
  logic        cur_we = 1'b0;
  int          exp_n = 0;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_strb [2];
  logic [31:0] exp_data [2];
  logic [31:0] exp_rd = 32'd0;
  logic        exp_err = 1'b0;
  int          exp_lat = 0;
  logic [31:0] held_rd = 32'd0;
  int          beat_idx = 0;
  logic        prev_done = 1'b0;

  logic [31:0] mem [logic [31:0]];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Byte-by-byte model: each accessed byte lands in the word holding its
  // address, at lane addr%4.
  task automatic model_setup(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int gw, input int rw);
    int size;
    int b;
    int lane;
    logic [31:0] w0;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] v;
    cur_we = we;
    exp_err = 1'b0;
    exp_rd = held_rd;
    for (int j = 0; j < 2; j++) begin
      exp_addr[j] = 32'd0;
      exp_strb[j] = 4'd0;
      exp_data[j] = 32'd0;
    end
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
      exp_n = 0;
      exp_err = 1'b1;
      exp_lat = 1;
    end else begin
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      w0 = {addr[31:2], 2'b00};
      exp_addr[0] = w0;
      exp_addr[1] = w0 + 32'd4;
      exp_n = 1;
      v = 32'd0;
      for (int i = 0; i < size; i++) begin
        a = addr + 32'(i);
        b = ({a[31:2], 2'b00} == w0) ? 0 : 1;
        if (b == 1) exp_n = 2;
        lane = int'(a[1:0]);
        exp_strb[b][lane] = 1'b1;
        exp_data[b][8*lane +: 8] = wdata[8*i +: 8];
        wd = mem_word({a[31:2], 2'b00});
        v[8*i +: 8] = wd[8*lane +: 8];
      end
      if (!we) begin
        case (f3)
          3'b000:  exp_rd = {{24{v[7]}}, v[7:0]};
          3'b001:  exp_rd = {{16{v[15]}}, v[15:0]};
          3'b100:  exp_rd = {24'd0, v[7:0]};
          3'b101:  exp_rd = {16'd0, v[15:0]};
          default: exp_rd = v;
        endcase
        exp_lat = 1 + exp_n * (gw + 1 + rw);
      end else begin
        exp_lat = 1 + exp_n * (gw + 1);
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("rst_ctrl", {28'd0, dm_req, dm_we, lsu_done, lsu_err}, 32'd0);
      check_output("rst_dm_addr", dm_addr, 32'd0);
      check_output("rst_dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
      check_output("rst_dm_wdata", dm_wdata, 32'd0);
      check_output("rst_rdata", lsu_rdata, 32'd0);
    end else begin
      check_output("stall", {31'd0, lsu_stall}, {31'd0, lsu_valid & ~lsu_done});
      check_output("err_without_done", {31'd0, lsu_err & ~lsu_done}, 32'd0);
      if (dm_req) begin
        if (beat_idx >= exp_n) begin
          check_output("unexpected_dm_req", {31'd0, dm_req}, 32'd0);
        end else begin
          check_output("dm_addr", dm_addr, exp_addr[beat_idx]);
          check_output("dm_we", {31'd0, dm_we}, {31'd0, cur_we});
          if (cur_we) begin
            check_output("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, exp_strb[beat_idx]});
            check_output("dm_wdata", dm_wdata, exp_data[beat_idx]);
          end
        end
      end
      if (lsu_done) begin
        check_output("done_single_pulse", {31'd0, prev_done}, 32'd0);
        check_output("lsu_err", {31'd0, lsu_err}, {31'd0, exp_err});
      end
      check_output("lsu_rdata", lsu_rdata, held_rd);
    end
    prev_done = lsu_done;
  end

  // One request from acceptance to lsu_done, acting as the memory:
  // gnt after gw cycles of dm_req, rvalid rw cycles after each load grant.
  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gw, input int rw);
    int k;
    int gnt_cnt;
    int rv_cnt;
    int lat;
    logic granted;
    logic done_seen;
    logic [31:0] rv_word;
    @(posedge clk); #1;
    model_setup(we, f3, addr, wdata, gw, rw);
    beat_idx = 0;
    lsu_valid = 1'b1;
    lsu_we = we;
    lsu_func3 = f3;
    lsu_addr = addr;
    lsu_wdata = wdata;
    gnt_cnt = 0;
    rv_cnt = 0;
    lat = 0;
    rv_word = 32'd0;
    done_seen = 1'b0;
    k = 0;
    while (!done_seen && k < 60) begin
      @(posedge clk); #1;
      k++;
      granted = dm_gnt;
      dm_gnt = 1'b0;
      dm_rvalid = 1'b0;
      if (granted) begin
        if (!cur_we && beat_idx < 2) begin
          rv_cnt = rw;
          rv_word = exp_addr[beat_idx];
        end
        beat_idx++;
        gnt_cnt = 0;
      end
      if (lsu_done) begin
        done_seen = 1'b1;
        lat = k;
        lsu_valid = 1'b0;
        if (!cur_we && !exp_err) held_rd = exp_rd;
      end
      if (dm_req) begin
        if (gnt_cnt >= gw) dm_gnt = 1'b1;
        else gnt_cnt++;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          dm_rvalid = 1'b1;
          dm_rdata = mem_word(rv_word);
        end
      end
    end
    lsu_valid = 1'b0;
    dm_gnt = 1'b0;
    dm_rvalid = 1'b0;
    if (!done_seen) check_output("done_timeout", 32'd0, 32'd1);
    else check_output("latency", lat, exp_lat);
  endtask

  initial begin
    mem[32'h0000_3000] = 32'h8000_0000;
    mem[32'h0000_3004] = 32'h0000_00FF;
    mem[32'h0000_5000] = 32'hCAFE_F00D;
    mem[32'h0000_6000] = 32'h8899_AABB;
    mem[32'h0000_4000] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // sb at 0x1003
    apply_stimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 1);
    check_output("pin_sb_addr", exp_addr[0], 32'h0000_1000);
    check_output("pin_sb_strb", {28'd0, exp_strb[0]}, 32'h8);
    check_output("pin_sb_data", exp_data[0], 32'hAB00_0000);
    check_output("pin_sb_lat", exp_lat, 32'd2);

    // split sw at 0x2002
    apply_stimulus(1'b1, 3'b010, 32'h0000_2002, 32'h1122_3344, 0, 1);
    check_output("pin_sw_b0_addr", exp_addr[0], 32'h0000_2000);
    check_output("pin_sw_b0_strb", {28'd0, exp_strb[0]}, 32'hC);
    check_output("pin_sw_b0_data", exp_data[0], 32'h3344_0000);
    check_output("pin_sw_b1_addr", exp_addr[1], 32'h0000_2004);
    check_output("pin_sw_b1_strb", {28'd0, exp_strb[1]}, 32'h3);
    check_output("pin_sw_b1_data", exp_data[1], 32'h0000_1122);
    check_output("pin_sw_lat", exp_lat, 32'd3);

    // split lh / lhu at 0x3003
    apply_stimulus(1'b0, 3'b001, 32'h0000_3003, 32'd0, 0, 1);
    check_output("pin_lh_rdata", exp_rd, 32'hFFFF_FF80);
    check_output("pin_lh_lat", exp_lat, 32'd5);
    apply_stimulus(1'b0, 3'b101, 32'h0000_3003, 32'd0, 0, 1);
    check_output("pin_lhu_rdata", exp_rd, 32'h0000_FF80);

    // wait states: gnt held low 3 cycles, rvalid 2 cycles after gnt
    apply_stimulus(1'b0, 3'b010, 32'h0000_5000, 32'd0, 3, 2);
    check_output("pin_ws_lw_rdata", exp_rd, 32'hCAFE_F00D);
    check_output("pin_ws_lw_lat", exp_lat, 32'd7);
    apply_stimulus(1'b1, 3'b001, 32'h0000_5002, 32'hBEEF_1234, 3, 1);

    // aligned store back-to-back with the previous one (new request in IDLE after DONE)
    apply_stimulus(1'b1, 3'b010, 32'h0000_5000, 32'h0102_0304, 0, 1);
    check_output("pin_sw_aligned_lat", exp_lat, 32'd2);

    // address wrap
    apply_stimulus(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 1);
    check_output("pin_wrap_b0_addr", exp_addr[0], 32'hFFFF_FFFC);
    check_output("pin_wrap_b1_addr", exp_addr[1], 32'h0000_0000);
    check_output("pin_wrap_b1_data", exp_data[1], 32'h00DE_ADBE);
    apply_stimulus(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 1, 1);

    // illegal func3 values, load and store
    apply_stimulus(1'b0, 3'b011, 32'h0000_7000, 32'd0, 0, 1);
    check_output("pin_illegal_lat", exp_lat, 32'd1);
    apply_stimulus(1'b0, 3'b110, 32'h0000_7001, 32'd0, 0, 1);
    apply_stimulus(1'b1, 3'b111, 32'h0000_7002, 32'h5555_5555, 0, 1);

    // assorted loads
    apply_stimulus(1'b0, 3'b000, 32'h0000_6001, 32'd0, 0, 1);
    check_output("pin_lb_rdata", exp_rd, 32'hFFFF_FFAA);
    apply_stimulus(1'b0, 3'b100, 32'h0000_6003, 32'd0, 0, 3);
    check_output("pin_lbu_rdata", exp_rd, 32'h0000_0088);
    apply_stimulus(1'b0, 3'b001, 32'h0000_6000, 32'd0, 2, 1);
    check_output("pin_lh_al_rdata", exp_rd, 32'hFFFF_AABB);
    apply_stimulus(1'b0, 3'b010, 32'h0000_6002, 32'd0, 0, 2);
    apply_stimulus(1'b1, 3'b000, 32'h0000_6001, 32'h0000_0077, 0, 1);

    // reset while waiting for read data
    @(posedge clk); #1;
    model_setup(1'b0, 3'b000, 32'h0000_4001, 32'd0, 0, 1);
    beat_idx = 0;
    lsu_valid = 1'b1;
    lsu_we = 1'b0;
    lsu_func3 = 3'b000;
    lsu_addr = 32'h0000_4001;
    @(posedge clk); #1;
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    beat_idx = 1;
    check_output("rsp_no_req", {31'd0, dm_req}, 32'd0);
    #2;
    rst_n = 1'b0;
    lsu_valid = 1'b0;
    held_rd = 32'd0;
    exp_n = 0;
    #1;
    check_output("async_rst_req", {31'd0, dm_req}, 32'd0);
    check_output("async_rst_done", {31'd0, lsu_done}, 32'd0);
    check_output("async_rst_rdata", lsu_rdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("post_rst_no_done", {31'd0, lsu_done}, 32'd0);
    end
    apply_stimulus(1'b0, 3'b000, 32'h0000_4001, 32'd0, 0, 1);
    check_output("pin_post_rst_lb", exp_rd, 32'h0000_0056);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
